// File: rtl/da_dct8_stream.sv
// 8-point DCT-II / transpose using bit-serial distributed arithmetic, MSB-first,
// with valid/ready handshakes on input and output.

module da_dct8_lane #(
    parameter int OUT_W = 21,
    parameter int IDX   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    msb,
    input  logic                    mode,
    input  logic [7:0]              bits,
    output logic signed [OUT_W-1:0] nxt
);
    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] p;

    function automatic logic signed [8:0] mag(int m);
        case (m)
            0:       mag = 9'sd256;
            1:       mag = 9'sd251;
            2:       mag = 9'sd237;
            3:       mag = 9'sd213;
            4:       mag = 9'sd181;
            5:       mag = 9'sd142;
            6:       mag = 9'sd98;
            default: mag = 9'sd50;
        endcase
    endfunction

    // cos((2n+1)k*pi/16) folded into the first quadrant of the 32-step circle
    function automatic logic signed [8:0] coef(int k, int n);
        int m;
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        if (k == 0)      coef = 9'sd181;
        else if (m < 8)  coef = mag(m);
        else             coef = -mag(16 - m);
    endfunction

    always_comb begin
        p = '0;
        for (int j = 0; j < 8; j++)
            if (bits[j])
                p = p + (mode ? OUT_W'(coef(j, IDX)) : OUT_W'(coef(IDX, j)));
        nxt = msb ? -p : (acc <<< 1) + p;
    end

    always_ff @(posedge clk) begin
        if (rst)      acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= nxt;
    end
endmodule

module da_dct8_stream #(
    parameter int IN_W  = 10,
    parameter int OUT_W = IN_W + 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic signed [IN_W-1:0]  a0, a1, a2, a3, a4, a5, a6, a7,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] z0, z1, z2, z3, z4, z5, z6, z7,
    output logic                    busy
);
    localparam int CW = $clog2(IN_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state;

    logic [CW-1:0]               cnt;
    logic                        md;
    logic [7:0][IN_W-1:0]        xs;
    logic [7:0][OUT_W-1:0]       zr;
    logic [7:0][OUT_W-1:0]       nxt;
    logic [7:0]                  plane;
    logic                        accept, msb;

    assign accept = (state == IDLE) && in_valid;
    assign msb    = (cnt == CW'(IN_W - 1));

    // One bit-plane of all eight latched samples feeds every lane
    always_comb begin
        plane = '0;
        for (int j = 0; j < 8; j++) plane[j] = xs[j][cnt];
    end

    for (genvar i = 0; i < 8; i++) begin : g_lane
        da_dct8_lane #(.OUT_W(OUT_W), .IDX(i)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (accept),
            .en   (state == CALC),
            .msb  (msb),
            .mode (md),
            .bits (plane),
            .nxt  (nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            md        <= 1'b0;
            xs        <= '0;
            zr        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xs       <= {a7, a6, a5, a4, a3, a2, a1, a0};
                    md       <= mode;
                    cnt      <= CW'(IN_W - 1);
                    state    <= CALC;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    // The bit-0 result goes straight to z; acc is not reread.
                    if (cnt == '0) begin
                        zr        <= nxt;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign z0 = zr[0];
    assign z1 = zr[1];
    assign z2 = zr[2];
    assign z3 = zr[3];
    assign z4 = zr[4];
    assign z5 = zr[5];
    assign z6 = zr[6];
    assign z7 = zr[7];
endmodule

// File: doc/da_dct8_stream.md
Name: da_dct8_stream

Overview:
- Parametrised successor to the fixed 8-point distributed-arithmetic (DA) transform top.
- Computes an 8-point DCT-II (forward) or its transpose (inverse, per-block mode select) on signed IN_W-bit samples.
- Uses bit-serial DA evaluation, MSB-first, one input bit-plane per clock.
- Adds valid/ready handshakes on both sides so the block can sit in a streaming datapath between a sample buffer and a result consumer.

Parameters:
- IN_W, 10, input sample width in bits; signed two's complement; legal range 4..16.
- OUT_W, IN_W+11, output width; signed two's complement. Derived value; must not be overridden below IN_W+11.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, a0..a7 and mode are valid this cycle.
- in_ready, output, 1, block can accept a new 8-sample block.
- mode, input, 1, 0 = forward, 1 = inverse. Sampled on accept.
- a0..a7, input, IN_W each, signed input samples x[0..7].
- out_valid, output, 1, z0..z7 hold a completed result.
- out_ready, input, 1, consumer accepts the result.
- z0..z7, output, OUT_W each, signed results.
- busy, output, 1, high in CALC or DONE.

Behaviour:
- Coefficient matrix C[k][n], integers, 8 fractional bits (not scaled back):
  - C[0][n] = 181
  - For k ≥ 1: C[k][n] = round(256·cos((2n+1)kπ/16)), giving magnitudes 251, 237, 213, 181, 142, 98, 50.
  - Row 1 = 251, 213, 142, 50, −50, −142, −213, −251.
- Forward: z_k = Σ_n C[k][n]·x_n.
- Inverse: z_n = Σ_k C[k][n]·x_k.
- Results are exact. No rounding or saturation; OUT_W guarantees no overflow.
- States: IDLE, CALC, DONE.
  - IDLE: in_ready=1, out_valid=0, busy=0. On in_valid=1, latch a0..a7 and mode, clear the accumulators and bit counter, go to CALC.
  - CALC: in_ready=0. Each clock processes bit b = IN_W−1 down to 0.
    - Per output, P = Σ over inputs of bit_b(x)·coef.
    - At the MSB: acc = −P. Otherwise: acc = 2·acc + P.
    - After the bit-0 edge, copy acc to z0..z7 and go to DONE.
  - DONE: out_valid=1, z held stable. On out_ready=1, go to IDLE (out_valid drops next cycle; z retains its value).
- Latency: out_valid rises on the IN_W-th rising edge after the accept edge.
- Throughput: one block per IN_W+2 cycles with out_ready tied high.
- in_ready is 0 outside IDLE. in_valid in CALC or DONE is ignored; no queuing, no data corruption.
- Changes to mode or a* after accept have no effect on the block in flight.
- out_ready while out_valid=0 is ignored.
- Reset (rst=1 at any edge, including mid-CALC or in DONE):
  - Next state is IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - z0..z7 = 0, accumulators = 0, counter = 0.
  - A block aborted by reset produces no output.
- Reset has priority over all handshakes in the same cycle.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, all z=0. No block is accepted while rst=1.
- All-ones forward: a0..a7=1, mode=0, out_ready=1 → out_valid rises 10 edges after accept. z0=1448, z1..z7=0. Next accept possible 12 cycles after the previous one.
- Impulse forward then inverse:
  - a0=1, others 0, mode=0 → z0..z7 = 181, 251, 237, 213, 181, 142, 98, 50.
  - Same input with mode=1 → all z=181.
- Extreme value: all a=−512 (IN_W=10), mode=0 → z0=−741376, z1..z7=0.
  - Then a0=511, a1=−512, others 0, mode=0 → z1 = 511·251 + (−512)·213 = 19205.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - z is stable; in_ready=0.
  - in_valid pulses with new data are ignored.
  - Raising out_ready → out_valid low next cycle, in_ready high.
- Mid-operation reset: assert rst on the 4th CALC cycle → IDLE on the next edge, z=0, no out_valid. A fresh impulse block afterwards yields the correct forward impulse result.
